ex_div_sequencer: RTL and testbench

- Multi-cycle integer divide controller and datapath for the RV32M DIV/DIVU/REM/REMU operations in the Execute stage.
- Accepts one divide request from Decode and runs a 32-step restoring divide.
- Holds the pipeline with a stall output while it works.
- Presents the result to the EX-MEM buffer for one cycle. A flush from the Flush Control path cancels the operation.

---
 rtl/ex_div_sequencer.sv | 160 ++++++++++++++++
 tb/tb_ex_div_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_sequencer.sv
// Multi-cycle RV32M divide/remainder sequencer for the Execute stage.
// Uses a restoring shift-subtract divider with one step per clock.
// The quotient and remainder are corrected for sign on entry to DONE.
module ex_div_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            div_req_ip,
  input  logic [1:0]      div_op_ip,
  input  logic [XLEN-1:0] dividend_ip,
  input  logic [XLEN-1:0] divisor_ip,
  input  logic            flush_ip,
  output logic            stall_op,
  output logic            busy_op,
  output logic [XLEN-1:0] div_result_op,
  output logic            div_valid_op
);

  localparam logic [XLEN-1:0] SMIN    = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN-1);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dsr_q, dsr_d;
  logic [1:0]        op_q, op_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              busy_q, busy_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              valid_q, valid_d;

  logic              signed_op, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     trial, diff;
  logic              no_borrow;
  logic [XLEN-1:0]   rem_step, quo_step, quo_fin, rem_fin;
  logic              stall_raw;

  // Operand conditioning and one restoring step
  always_comb begin
    signed_op = ~div_op_ip[0];
    a_neg     = signed_op & dividend_ip[XLEN-1];
    b_neg     = signed_op & divisor_ip[XLEN-1];
    a_mag     = a_neg ? -dividend_ip : dividend_ip;
    b_mag     = b_neg ? -divisor_ip : divisor_ip;
    trial     = {rem_q, quo_q[XLEN-1]};
    diff      = trial - {1'b0, dsr_q};
    no_borrow = ~diff[XLEN];
    rem_step  = no_borrow ? diff[XLEN-1:0] : trial[XLEN-1:0];
    quo_step  = {quo_q[XLEN-2:0], no_borrow};
    quo_fin   = neg_quo_q ? -quo_step : quo_step;
    rem_fin   = neg_rem_q ? -rem_step : rem_step;
  end

  // Next-state, datapath update and output selection
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    stall_raw = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        stall_raw = div_req_ip & ~flush_ip;
        if (div_req_ip && !flush_ip) begin
          op_d      = div_op_ip;
          rem_d     = '0;
          quo_d     = a_mag;
          dsr_d     = b_mag;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          cnt_d     = '0;
          if (divisor_ip == '0) begin
            state_d  = ST_DONE;
            valid_d  = 1'b1;
            result_d = div_op_ip[1] ? dividend_ip : ONES;
          end else if (signed_op && dividend_ip == SMIN && divisor_ip == ONES) begin
            state_d  = ST_DONE;
            valid_d  = 1'b1;
            result_d = div_op_ip[1] ? '0 : SMIN;
          end else begin
            state_d  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        stall_raw = 1'b1;
        if (flush_ip) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d  = ST_DONE;
            valid_d  = 1'b1;
            result_d = op_q[1] ? rem_fin : quo_fin;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d   = (state_d != ST_IDLE);
    stall_op = reset & stall_raw;
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      op_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
    end
  end

  assign busy_op       = busy_q;
  assign div_result_op = result_q;
  assign div_valid_op  = valid_q;

endmodule

// File: tb/tb_ex_div_sequencer.sv
// Randomized self-checking bench for ex_div_sequencer against an arithmetic model.
module tb_ex_div_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        div_req_ip;
  logic [1:0]  div_op_ip;
  logic [31:0] dividend_ip;
  logic [31:0] divisor_ip;
  logic        flush_ip;
  logic        stall_op;
  logic        busy_op;
  logic [31:0] div_result_op;
  logic        div_valid_op;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_result = '0;

  ex_div_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clock         (clock),
    .reset         (reset),
    .div_req_ip    (div_req_ip),
    .div_op_ip     (div_op_ip),
    .dividend_ip   (dividend_ip),
    .divisor_ip    (divisor_ip),
    .flush_ip      (flush_ip),
    .stall_op      (stall_op),
    .busy_op       (busy_op),
    .div_result_op (div_result_op),
    .div_valid_op  (div_valid_op)
  );

  always #5 clock = ~clock;

  // Single comparison point for every check
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // RV32M result from plain integer arithmetic
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return op[1] ? r[31:0] : q[31:0];
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Issue one request, scribble ignored inputs while busy, check latency and result
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int exp_stall, stalls, vcnt, vcyc;
    logic [31:0] res;
    bit done;
    exp       = model(op, a, b);
    exp_stall = is_special(op, a, b) ? 1 : 33;
    stalls = 0; vcnt = 0; vcyc = 0; res = '0; done = 0;
    @(negedge clock);
    div_req_ip = 1'b1; div_op_ip = op; dividend_ip = a; divisor_ip = b; flush_ip = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      if (c > 1) begin
        @(negedge clock);
        if (vcnt == 0) begin
          div_req_ip  = 1'($urandom_range(0, 1));
          div_op_ip   = 2'($urandom_range(0, 3));
          dividend_ip = $urandom;
          divisor_ip  = $urandom;
        end else begin
          div_req_ip = 1'b0;
        end
      end
      #1;
      if (stall_op) stalls++;
      if (div_valid_op) begin
        vcnt++;
        vcyc = c;
        res  = div_result_op;
        div_req_ip = 1'b0;
      end
      if (vcnt > 0 && c >= vcyc + 2) done = 1;
    end
    check_eq({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    check_eq({tag, "_valid_cycle"}, 32'(vcyc), 32'(exp_stall + 1));
    check_eq({tag, "_valid_pulses"}, 32'(vcnt), 32'd1);
    check_eq({tag, "_result"}, res, exp);
    check_eq({tag, "_result_hold"}, div_result_op, exp);
    check_eq({tag, "_busy_after"}, 32'(busy_op), 32'd0);
    last_result = exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [31:0] prev;
    logic [31:0] res_seen [2];
    int vcnt, vcyc2;

    reset = 1'b0; div_req_ip = 1'b1; div_op_ip = 2'd1;
    dividend_ip = 32'd100; divisor_ip = 32'd7; flush_ip = 1'b0;
    #22;
    check_eq("rst_stall", 32'(stall_op), 32'd0);
    check_eq("rst_busy", 32'(busy_op), 32'd0);
    check_eq("rst_valid", 32'(div_valid_op), 32'd0);
    check_eq("rst_result", div_result_op, 32'd0);
    @(negedge clock);
    div_req_ip = 1'b0;
    reset = 1'b1;

    run_op(2'd1, 32'd100, 32'd7, "divu_100_7");
    run_op(2'd3, 32'd100, 32'd7, "remu_100_7");
    run_op(2'd0, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run_op(2'd2, 32'd7, 32'hFFFF_FFFE, "rem_7_m2");
    run_op(2'd1, 32'd1234, 32'd0, "divu_by0");
    run_op(2'd3, 32'd1234, 32'd0, "remu_by0");
    run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
    end

    // Flush in the tenth CALC cycle
    prev = last_result;
    @(negedge clock);
    div_req_ip = 1'b1; div_op_ip = 2'd1; dividend_ip = 32'd50; divisor_ip = 32'd3;
    @(negedge clock);
    div_req_ip = 1'b0;
    for (int c = 3; c <= 11; c++) @(negedge clock);
    flush_ip = 1'b1;
    @(negedge clock);
    flush_ip = 1'b0;
    #1;
    check_eq("flush_busy", 32'(busy_op), 32'd0);
    check_eq("flush_stall", 32'(stall_op), 32'd0);
    vcnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (div_valid_op) vcnt++;
      @(negedge clock); #1;
    end
    check_eq("flush_no_valid", 32'(vcnt), 32'd0);
    check_eq("flush_result_kept", div_result_op, prev);

    // Asynchronous reset in the middle of CALC
    @(negedge clock);
    div_req_ip = 1'b1; div_op_ip = 2'd1; dividend_ip = 32'd1000; divisor_ip = 32'd7;
    @(negedge clock);
    div_req_ip = 1'b0;
    repeat (12) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(div_valid_op), 32'd0);
    check_eq("midrst_busy", 32'(busy_op), 32'd0);
    check_eq("midrst_stall", 32'(stall_op), 32'd0);
    check_eq("midrst_result", div_result_op, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock); #1;
      if (div_valid_op) vcnt++;
    end
    check_eq("midrst_no_valid", 32'(vcnt), 32'd0);

    // Back-to-back with request held through DONE
    @(negedge clock);
    div_req_ip = 1'b1; div_op_ip = 2'd1; dividend_ip = 32'd9; divisor_ip = 32'd3;
    vcnt = 0; vcyc2 = 0;
    res_seen[0] = '0; res_seen[1] = '0;
    for (int c = 1; c <= 80; c++) begin
      if (c > 1) @(negedge clock);
      #1;
      if (div_valid_op) begin
        if (vcnt < 2) res_seen[vcnt] = div_result_op;
        vcnt++;
        if (vcnt == 1) begin dividend_ip = 32'd8; divisor_ip = 32'd2; end
        if (vcnt == 2) begin vcyc2 = c; div_req_ip = 1'b0; end
      end
    end
    check_eq("b2b_pulses", 32'(vcnt), 32'd2);
    check_eq("b2b_first", res_seen[0], 32'd3);
    check_eq("b2b_second", res_seen[1], 32'd4);
    check_eq("b2b_second_cycle", 32'(vcyc2), 32'd68);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
